// File: rtl/sensor_sample_fifo.sv
// Sample buffer behind the sensor transaction controller: tags captured bytes with an
// error bit, inserts one marker per NORESPOND entry, and tracks fill/overflow status.
module sensor_sample_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_state,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  input  logic              i_err,
  output logic [DATA_W:0]   o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  output logic [7:0]        o_drop_cnt,
  output logic              o_norespond
);

  localparam logic [3:0]      ST_CONFIGREAD = 4'b0010;
  localparam logic [3:0]      ST_READING    = 4'b0100;
  localparam logic [3:0]      ST_NORESPOND  = 4'b1000;
  localparam logic [ADDR_W:0] FULL_CNT      = (ADDR_W+1)'(DEPTH);

  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [3:0]        prev_state;

  logic              data_push;
  logic              marker_push;
  logic              push_req;
  logic              push_ok;
  logic              drop;
  logic              pop;
  logic [DATA_W:0]   push_entry;

  always_comb begin
    data_push   = i_data_valid & ((i_state == ST_CONFIGREAD) | (i_state == ST_READING));
    marker_push = (i_state == ST_NORESPOND) & (prev_state != ST_NORESPOND);
    push_req    = data_push | marker_push;
    pop         = o_valid & i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
    push_ok     = push_req & (~o_full | pop);
    drop        = push_req & ~push_ok;
    if (marker_push)
      push_entry = {1'b1, {DATA_W{1'b1}}};
    else if (i_state == ST_CONFIGREAD)
      push_entry = {1'b1, i_data};
    else
      push_entry = {i_err, i_data};
  end

  always_ff @(posedge i_clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      prev_state  <= '0;
      o_overflow  <= 1'b0;
      o_drop_cnt  <= '0;
      o_norespond <= 1'b0;
    end else begin
      prev_state <= i_state;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok & ~pop)
        o_count <= o_count + 1'b1;
      else if (pop & ~push_ok)
        o_count <= o_count - 1'b1;
      if (drop) begin
        o_overflow <= 1'b1;
        if (o_drop_cnt != 8'hFF)
          o_drop_cnt <= o_drop_cnt + 1'b1;
      end
      if (marker_push)
        o_norespond <= 1'b1;
    end
  end

  assign o_full  = (o_count == FULL_CNT);
  assign o_empty = (o_count == '0);
  assign o_valid = ~o_empty;
  assign o_data  = mem[rd_ptr];

endmodule

// File: tb/tb_sensor_sample_fifo.sv
// Directed bench for sensor_sample_fifo: tagging, state gating, overflow, full+pop,
// NORESPOND marker and reset behaviour, with hand-computed expectations.
module tb_sensor_sample_fifo;

  localparam logic [3:0] ADDR = 4'b0000, CFGW = 4'b0001, CFGR = 4'b0010,
                         READ = 4'b0100, NORSP = 4'b1000;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [3:0] i_state;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       i_err;
  logic [8:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [4:0] o_count;
  logic       o_full;
  logic       o_empty;
  logic       o_overflow;
  logic [7:0] o_drop_cnt;
  logic       o_norespond;

  int n_cmp = 0;
  int n_err = 0;

  sensor_sample_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_state(i_state), .i_data(i_data),
    .i_data_valid(i_data_valid), .i_err(i_err), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
    .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt), .o_norespond(o_norespond)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_state = ADDR; i_data_valid = 1'b0; i_ready = 1'b0;
    step();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_count !== 5'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", o_count); end
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b exp 1", o_empty); end
    n_cmp++; if (o_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b exp 0", o_full); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow got %b exp 0", o_overflow); end
    n_cmp++; if (o_drop_cnt !== 8'd0) begin n_err++; $display("FAIL rst_drop got %0d exp 0", o_drop_cnt); end
    n_cmp++; if (o_norespond !== 1'b0) begin n_err++; $display("FAIL rst_norsp got %b exp 0", o_norespond); end
  endtask

  task automatic test_tagging();
    do_reset();
    i_state = CFGR; i_data = 8'h11; i_data_valid = 1'b1; i_err = 1'b0;
    step();
    n_cmp++; if (o_data !== 9'h111) begin n_err++; $display("FAIL tag_latency got %h exp 111", o_data); end
    i_state = READ; i_data = 8'h22; i_err = 1'b0;
    step();
    i_data_valid = 1'b0; i_state = ADDR;
    n_cmp++; if (o_count !== 5'd2) begin n_err++; $display("FAIL tag_count got %0d exp 2", o_count); end
    n_cmp++; if (o_data !== 9'h111) begin n_err++; $display("FAIL tag_first got %h exp 111", o_data); end
    i_ready = 1'b1;
    step();
    n_cmp++; if (o_data !== 9'h022) begin n_err++; $display("FAIL tag_second got %h exp 022", o_data); end
    n_cmp++; if (o_count !== 5'd1) begin n_err++; $display("FAIL tag_count1 got %0d exp 1", o_count); end
    step();
    i_ready = 1'b0;
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL tag_empty got %b exp 1", o_empty); end
  endtask

  task automatic test_gating();
    do_reset();
    i_data = 8'h5A; i_err = 1'b1; i_data_valid = 1'b1;
    i_state = ADDR;
    for (int i = 0; i < 5; i++) step();
    i_state = CFGW;
    for (int i = 0; i < 5; i++) step();
    i_data_valid = 1'b0; i_state = ADDR;
    n_cmp++; if (o_count !== 5'd0) begin n_err++; $display("FAIL gate_count got %0d exp 0", o_count); end
    n_cmp++; if (o_drop_cnt !== 8'd0) begin n_err++; $display("FAIL gate_drop got %0d exp 0", o_drop_cnt); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL gate_overflow got %b exp 0", o_overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    i_state = READ; i_err = 1'b0; i_data_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      i_data = 8'h30 + 8'(i);
      step();
    end
    i_data_valid = 1'b0; i_state = ADDR;
    n_cmp++; if (o_full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b exp 1", o_full); end
    n_cmp++; if (o_count !== 5'd16) begin n_err++; $display("FAIL ovf_count got %0d exp 16", o_count); end
    n_cmp++; if (o_drop_cnt !== 8'd2) begin n_err++; $display("FAIL ovf_drop got %0d exp 2", o_drop_cnt); end
    n_cmp++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", o_overflow); end
    i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (o_valid !== 1'b1 || o_data !== {1'b0, 8'h30 + 8'(i)}) begin
        n_err++; $display("FAIL ovf_drain%0d got v=%b d=%h exp v=1 d=%h", i, o_valid, o_data, {1'b0, 8'h30 + 8'(i)});
      end
      step();
    end
    i_ready = 1'b0;
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty got %b exp 1", o_empty); end
    n_cmp++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", o_overflow); end
  endtask

  task automatic test_full_pop();
    logic [8:0] exp_d;
    do_reset();
    i_state = READ; i_err = 1'b0; i_data_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_data = 8'h40 + 8'(i);
      step();
    end
    i_data = 8'hAA; i_ready = 1'b1;
    step();
    i_data_valid = 1'b0; i_state = ADDR; i_ready = 1'b0;
    n_cmp++; if (o_count !== 5'd16) begin n_err++; $display("FAIL fp_count got %0d exp 16", o_count); end
    n_cmp++; if (o_drop_cnt !== 8'd0) begin n_err++; $display("FAIL fp_drop got %0d exp 0", o_drop_cnt); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL fp_overflow got %b exp 0", o_overflow); end
    i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_d = (i == 15) ? 9'h0AA : {1'b0, 8'h41 + 8'(i)};
      n_cmp++;
      if (o_data !== exp_d) begin n_err++; $display("FAIL fp_drain%0d got %h exp %h", i, o_data, exp_d); end
      step();
    end
    i_ready = 1'b0;
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL fp_empty got %b exp 1", o_empty); end
  endtask

  task automatic test_marker();
    do_reset();
    i_state = READ; i_data_valid = 1'b0;
    step();
    i_state = NORSP;
    for (int i = 0; i < 10; i++) step();
    n_cmp++; if (o_count !== 5'd1) begin n_err++; $display("FAIL mk_count got %0d exp 1", o_count); end
    n_cmp++; if (o_data !== 9'h1FF) begin n_err++; $display("FAIL mk_data got %h exp 1ff", o_data); end
    n_cmp++; if (o_norespond !== 1'b1) begin n_err++; $display("FAIL mk_norsp got %b exp 1", o_norespond); end
    i_ready = 1'b1;
    step();
    step();
    step();
    i_ready = 1'b0;
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL mk_single got %b exp 1", o_empty); end
    do_reset();
    n_cmp++; if (o_norespond !== 1'b0) begin n_err++; $display("FAIL mk_rst_norsp got %b exp 0", o_norespond); end
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL mk_rst_empty got %b exp 1", o_empty); end
    // NORESPOND held through reset: prev_state restarts at 0000, so a marker appears.
    i_rst = 1'b1; i_state = NORSP;
    step();
    i_rst = 1'b0;
    step();
    i_state = ADDR;
    n_cmp++; if (o_count !== 5'd1 || o_data !== 9'h1FF) begin n_err++; $display("FAIL mk_post_rst got c=%0d d=%h exp c=1 d=1ff", o_count, o_data); end
    n_cmp++; if (o_norespond !== 1'b1) begin n_err++; $display("FAIL mk_post_rst_norsp got %b exp 1", o_norespond); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_state = READ; i_err = 1'b1; i_data_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      i_data = 8'h60 + 8'(i);
      step();
    end
    n_cmp++; if (o_count !== 5'd7) begin n_err++; $display("FAIL rm_fill got %0d exp 7", o_count); end
    i_data = 8'h77; i_rst = 1'b1; i_ready = 1'b1;
    step();
    i_rst = 1'b0; i_data_valid = 1'b0; i_ready = 1'b0; i_state = ADDR;
    n_cmp++; if (o_count !== 5'd0) begin n_err++; $display("FAIL rm_count got %0d exp 0", o_count); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b exp 0", o_valid); end
    step();
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL rm_lost got %b exp 1", o_empty); end
  endtask

  initial begin
    i_rst = 1'b1; i_state = ADDR; i_data = '0; i_data_valid = 1'b0; i_err = 1'b0; i_ready = 1'b0;
    test_reset();
    test_tagging();
    test_gating();
    test_overflow();
    test_full_pop();
    test_marker();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
